// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage core: operand forwarding, load-use, branch flush,
// multi-cycle execute and memory wait-state stalls, plus a stall-cycle counter.
module hazard_unit_mc #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              reg_writeM,
  input  logic              reg_writeW,
  input  logic              result_src_b0E,
  input  logic              pc_srcE,
  input  logic              mdu_opE,
  input  logic              dmem_reqM,
  input  logic              dmem_readyM,
  output logic [1:0]        forward_AE,
  output logic [1:0]        forward_BE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int   CW     = $clog2(MDU_LAT + 1);
  localparam logic MDU_MC = (MDU_LAT > 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_t;

  mdu_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic mem_stall, load_stall, mdu_stall;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rd_m,
                                         input logic              we_m,
                                         input logic [REG_AW-1:0] rd_w,
                                         input logic              we_w);
    if (rs == '0)                 return 2'b00;
    else if (rs == rd_m && we_m)  return 2'b10;
    else if (rs == rd_w && we_w)  return 2'b01;
    else                          return 2'b00;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Memory waits freeze the MDU sequence: the op cannot leave E meanwhile.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mdu_opE && MDU_MC && !mem_stall) begin
          if (MDU_LAT == 2) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = CW'(MDU_LAT - 3);
          end
        end
      end
      BUSY: begin
        if (!mem_stall) begin
          if (cnt_q == '0) state_d = DONE;
          else             cnt_d   = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (!mem_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    forward_AE = fwd_sel(Rs1E, RdM, reg_writeM, RdW, reg_writeW);
    forward_BE = fwd_sel(Rs2E, RdM, reg_writeM, RdW, reg_writeW);

    mem_stall  = dmem_reqM & ~dmem_readyM;
    load_stall = result_src_b0E & (RdE != '0) & ((Rs1D == RdE) | (Rs2D == RdE));
    mdu_stall  = (state_q == BUSY) | ((state_q == IDLE) & mdu_opE & MDU_MC);

    stallE = mem_stall | mdu_stall;
    stallM = mem_stall;
    flushW = mem_stall;
    stallF = stallE | load_stall;
    stallD = stallE | load_stall;
    flushM = mdu_stall & ~mem_stall;
    // Redirects are deferred while E is held; the branch re-presents on release.
    flushD = pc_srcE & ~stallE;
    flushE = (pc_srcE | load_stall) & ~stallE;

    stall_cnt_d = stall_cnt_q;
    if (stallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    stall_cnt = stall_cnt_q;
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares against a 16-bit and a 2-bit counter instance.
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       reg_writeM, reg_writeW, result_src_b0E, pc_srcE, mdu_opE;
  logic       dmem_reqM, dmem_readyM;

  logic [1:0]  forward_AE, forward_BE;
  logic        stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW;
  logic [15:0] stall_cnt;

  logic [1:0] f2_a, f2_b;
  logic       s2_f, s2_d, s2_e, s2_m, l2_d, l2_e, l2_m, l2_w;
  logic [1:0] stall_cnt2;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(5), .MDU_LAT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .reg_writeM(reg_writeM), .reg_writeW(reg_writeW),
    .result_src_b0E(result_src_b0E), .pc_srcE(pc_srcE), .mdu_opE(mdu_opE),
    .dmem_reqM(dmem_reqM), .dmem_readyM(dmem_readyM),
    .forward_AE(forward_AE), .forward_BE(forward_BE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .stall_cnt(stall_cnt)
  );

  hazard_unit_mc #(.REG_AW(5), .MDU_LAT(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .reg_writeM(reg_writeM), .reg_writeW(reg_writeW),
    .result_src_b0E(result_src_b0E), .pc_srcE(pc_srcE), .mdu_opE(mdu_opE),
    .dmem_reqM(dmem_reqM), .dmem_readyM(dmem_readyM),
    .forward_AE(f2_a), .forward_BE(f2_b),
    .stallF(s2_f), .stallD(s2_d), .stallE(s2_e), .stallM(s2_m),
    .flushD(l2_d), .flushE(l2_e), .flushM(l2_m), .flushW(l2_w),
    .stall_cnt(stall_cnt2)
  );

  typedef struct {
    string       nm;
    logic [11:0] v;    // {fA, fB, stallF,D,E,M, flushD,E,M,W}
    logic [15:0] c;
    logic [1:0]  c2;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t        e;
      logic [11:0] act;
      e   = exp_q.pop_front();
      act = {forward_AE, forward_BE, stallF, stallD, stallE, stallM,
             flushD, flushE, flushM, flushW};
      n_cmp++;
      if (act !== e.v || stall_cnt !== e.c || stall_cnt2 !== e.c2) begin
        n_bad++;
        $display("FAIL %s: got flags=%03h cnt=%0d cnt2=%0d, want flags=%03h cnt=%0d cnt2=%0d",
                 e.nm, act, stall_cnt, stall_cnt2, e.v, e.c, e.c2);
      end
    end
  end

  task automatic clr_in();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    reg_writeM = 0; reg_writeW = 0; result_src_b0E = 0; pc_srcE = 0;
    mdu_opE = 0; dmem_reqM = 0; dmem_readyM = 0;
  endtask

  // Push the expectation for the current cycle, then advance to just after the next edge.
  task automatic chk(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                     input logic [3:0] st, input logic [3:0] fl, input int cnt);
    exp_t e;
    e.nm = nm;
    e.v  = {fa, fb, st, fl};
    e.c  = 16'(cnt);
    e.c2 = (cnt > 3) ? 2'd3 : 2'(cnt);
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    clr_in();
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 2'b00, 2'b00, 4'b0000, 4'b0000, 0);
    rst = 1'b0;
    chk("idle_zero", 2'b00, 2'b00, 4'b0000, 4'b0000, 0);

    // Forwarding priority
    Rs1E = 5; Rs2E = 5; RdM = 5; reg_writeM = 1; RdW = 5; reg_writeW = 1;
    chk("fwd_m", 2'b10, 2'b10, 4'b0000, 4'b0000, 0);
    reg_writeM = 0;
    chk("fwd_w", 2'b01, 2'b01, 4'b0000, 4'b0000, 0);
    Rs1E = 0;
    chk("fwd_x0", 2'b00, 2'b01, 4'b0000, 4'b0000, 0);
    Rs2E = 6; RdM = 6; reg_writeM = 1;
    chk("fwd_b_m", 2'b00, 2'b10, 4'b0000, 4'b0000, 0);
    Rs1E = 9;
    chk("fwd_miss", 2'b00, 2'b10, 4'b0000, 4'b0000, 0);
    clr_in();

    // Load-use
    result_src_b0E = 1; RdE = 7; Rs2D = 7;
    chk("load_use", 2'b00, 2'b00, 4'b1100, 4'b0100, 0);
    clr_in();
    chk("load_gone", 2'b00, 2'b00, 4'b0000, 4'b0000, 1);
    result_src_b0E = 1; RdE = 0; Rs1D = 0; Rs2D = 0;
    chk("load_x0", 2'b00, 2'b00, 4'b0000, 4'b0000, 1);
    clr_in();

    // MDU latency 4: three stalled cycles then release
    mdu_opE = 1;
    chk("mdu_c0", 2'b00, 2'b00, 4'b1110, 4'b0010, 1);
    chk("mdu_c1", 2'b00, 2'b00, 4'b1110, 4'b0010, 2);
    chk("mdu_c2", 2'b00, 2'b00, 4'b1110, 4'b0010, 3);
    chk("mdu_done", 2'b00, 2'b00, 4'b0000, 4'b0000, 4);
    mdu_opE = 0;
    chk("mdu_idle", 2'b00, 2'b00, 4'b0000, 4'b0000, 4);

    // MDU with two memory-wait cycles while BUSY, then branch deferred over the stall
    mdu_opE = 1;
    chk("mw_c0", 2'b00, 2'b00, 4'b1110, 4'b0010, 4);
    dmem_reqM = 1;
    chk("mw_wait0", 2'b00, 2'b00, 4'b1111, 4'b0001, 5);
    chk("mw_wait1", 2'b00, 2'b00, 4'b1111, 4'b0001, 6);
    dmem_reqM = 0;
    chk("mw_c1", 2'b00, 2'b00, 4'b1110, 4'b0010, 7);
    pc_srcE = 1;
    chk("br_stalled", 2'b00, 2'b00, 4'b1110, 4'b0010, 8);
    chk("br_release", 2'b00, 2'b00, 4'b0000, 4'b1100, 9);
    clr_in();
    chk("mw_idle", 2'b00, 2'b00, 4'b0000, 4'b0000, 9);

    // Asynchronous reset in the middle of BUSY
    mdu_opE = 1;
    chk("rb_c0", 2'b00, 2'b00, 4'b1110, 4'b0010, 9);
    chk("rb_c1", 2'b00, 2'b00, 4'b1110, 4'b0010, 10);
    rst = 1'b1; mdu_opE = 0;
    chk("rb_reset", 2'b00, 2'b00, 4'b0000, 4'b0000, 0);
    rst = 1'b0;
    chk("rb_after", 2'b00, 2'b00, 4'b0000, 4'b0000, 0);

    // Continuous memory stall: 2-bit counter saturates at 3
    dmem_reqM = 1;
    chk("sat0", 2'b00, 2'b00, 4'b1111, 4'b0001, 0);
    chk("sat1", 2'b00, 2'b00, 4'b1111, 4'b0001, 1);
    chk("sat2", 2'b00, 2'b00, 4'b1111, 4'b0001, 2);
    chk("sat3", 2'b00, 2'b00, 4'b1111, 4'b0001, 3);
    chk("sat4", 2'b00, 2'b00, 4'b1111, 4'b0001, 4);
    clr_in();
    chk("sat_hold", 2'b00, 2'b00, 4'b0000, 4'b0000, 5);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
